fibo_request_sequencer: RTL

- Front-end stage directly upstream of the memoized Fibonacci engine.
- Accepts operand requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the engine's operand input one request at a time and waits for the engine's ready.
- Returns each result with its operand over a valid/ready response handshake. Out-of-range operands are rejected without going to the engine.

---
 rtl/fibo_request_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fibo_request_sequencer.sv
// Request sequencer in front of the memoized Fibonacci engine. It buffers requests, range-checks them, waits out the engine's ready guard window, and returns responses in order.
// Optional watchdog on the engine wait: define FIBO_SEQ_TIMEOUT_EN.

module fibo_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

module fibo_request_sequencer #(
  parameter int DEPTH          = 4,
  parameter int MAX_OPERAND    = 23,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [11:0] req_operand,
  output logic        req_ready,
  output logic [11:0] eng_operand,
  input  logic        eng_ready,
  input  logic [15:0] eng_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [11:0] resp_operand,
  output logic [15:0] resp_value,
  output logic        resp_error,
  output logic        busy
);
  localparam int GW = $clog2(GUARD_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, CHECK, GUARD, WAIT, RESP} state_t;

  typedef struct packed {
    logic [11:0] operand;
    logic [15:0] value;
    logic        error;
  } resp_t;

  state_t        state, state_nxt;
  logic [11:0]   op_reg;
  logic [GW-1:0] guard_cnt;
  resp_t         resp_q, resp_d;
  logic [11:0]   fifo_head;
  logic          fifo_full, fifo_empty;
  logic          push, load_op, load_eng, load_resp, tmo_hit;

  // req_ready comes from the registered count, so a full FIFO never takes a push
  // even in a cycle where the FSM pops.
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;

  fibo_req_fifo #(.DEPTH(DEPTH), .W(12)) u_fifo (
    .clk       (CLK),
    .rst       (reset),
    .push      (push),
    .push_data (req_operand),
    .pop       (load_op),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FIBO_SEQ_TIMEOUT_EN
  logic [11:0] tmo_cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                                   tmo_cnt <= '0;
    else if (load_eng)                           tmo_cnt <= '0;
    else if ((state == GUARD || state == WAIT) && tmo_cnt != 12'hFFF)
                                                 tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == WAIT) && !eng_ready && (tmo_cnt >= 12'(TIMEOUT_CYCLES));
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_op   = 1'b0;
    load_eng  = 1'b0;
    load_resp = 1'b0;
    resp_d    = resp_q;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load_op   = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (op_reg > 12'(MAX_OPERAND)) begin
          resp_d    = '{operand: op_reg, value: 16'hFFFF, error: 1'b1};
          load_resp = 1'b1;
          state_nxt = RESP;
        end else begin
          load_eng  = 1'b1;
          state_nxt = GUARD;
        end
      end
      // The engine's ready still reflects the previous operand here.
      GUARD: begin
        if (guard_cnt <= GW'(1)) state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_ready) begin
          resp_d    = '{operand: op_reg, value: eng_result, error: 1'b0};
          load_resp = 1'b1;
          state_nxt = RESP;
        end else if (tmo_hit) begin
          resp_d    = '{operand: op_reg, value: 16'hFFFF, error: 1'b1};
          load_resp = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      op_reg      <= '0;
      eng_operand <= '0;
      guard_cnt   <= '0;
      resp_q      <= '0;
    end else begin
      if (load_op) op_reg <= fifo_head;
      if (load_eng) begin
        eng_operand <= op_reg;
        guard_cnt   <= GW'(GUARD_CYCLES);
      end else if (state == GUARD) begin
        guard_cnt   <= guard_cnt - 1'b1;
      end
      if (load_resp) resp_q <= resp_d;
    end
  end

  assign resp_valid   = (state == RESP);
  assign resp_operand = resp_q.operand;
  assign resp_value   = resp_q.value;
  assign resp_error   = resp_q.error;
  assign busy         = (state != IDLE) || !fifo_empty;
endmodule
